neuron_pulse_sequencer: RTL and testbench

Responder side of the neuron control handshake. It accepts CDS and sample triggers plus a pulse count from the matmul test sequencers. It generates the chip-facing CDS reset/settle phases and the input-pulse train, and reports completion on `idle`. It sits between the host-level sequencers and the NeuRRAM core pin drivers.

---
 rtl/neurram_ctrl_pkg.sv | 21 ++
 rtl/neuron_pulse_sequencer_phase_timer.sv | 31 +++
 rtl/neuron_pulse_sequencer.sv | 175 +++++++++++++++++
 tb/tb_neuron_pulse_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/neurram_ctrl_pkg.sv
// Shared definitions for the neuron control sequencers: state encoding,
// counter width and the zero-means-one timing rule.
package neurram_ctrl_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CDS_RESET  = 3'd1,
    ST_CDS_SETTLE = 3'd2,
    ST_PULSE_HIGH = 3'd3,
    ST_PULSE_LOW  = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

  function automatic logic [CNT_W-1:0] eff(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_ONE : v;
  endfunction

endpackage

// File: rtl/neuron_pulse_sequencer_phase_timer.sv
// Down-counting phase timer shared by every timed state; done_o marks the
// last cycle of the phase that was loaded.
module phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/neuron_pulse_sequencer.sv
// Neuron CDS / input-pulse sequencer: responds to trigger edges from the
// matmul test sequencers and drives the core's reset, settle and pulse strobes.
//
// state          | meaning
// ST_IDLE        | waiting for a trigger edge, idle = 1
// ST_CDS_RESET   | neuron_reset high for cds_cycles
// ST_CDS_SETTLE  | neuron_cds high for cds_cycles
// ST_PULSE_HIGH  | input_pulse high for pulse_width
// ST_PULSE_LOW   | input_pulse low for pulse_gap
// ST_DONE        | one quiet cycle before returning to idle
module neuron_pulse_sequencer
  import neurram_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cds_trigger,
  input  logic             sample_trigger,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic [CNT_W-1:0] pulse_gap,
  input  logic [CNT_W-1:0] cds_cycles,
  output logic             idle,
  output logic             neuron_reset,
  output logic             neuron_cds,
  output logic             neuron_sample,
  output logic             input_pulse,
  output logic [CNT_W-1:0] pulse_count,
  output logic             trig_dropped
);

  state_e state_q, state_d;

  logic cds_trig_q, sample_trig_q;
  logic cds_rise, sample_rise;
  logic [CNT_W-1:0] cds_len_q, width_q, gap_q, rem_q, pulse_count_q;
  logic idle_q, reset_q, cds_q, sample_q, pulse_q, dropped_q;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_done;

  assign cds_rise    = cds_trigger & ~cds_trig_q;
  assign sample_rise = sample_trigger & ~sample_trig_q;

  phase_timer #(.W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .done_o  (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      ST_IDLE: begin
        if (cds_rise) begin
          state_d   = ST_CDS_RESET;
          tmr_load  = 1'b1;
          tmr_value = eff(cds_cycles);
        end else if (sample_rise) begin
          if (num_pulses != '0) begin
            state_d   = ST_PULSE_HIGH;
            tmr_load  = 1'b1;
            tmr_value = eff(pulse_width);
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_CDS_RESET: begin
        if (tmr_done) begin
          state_d   = ST_CDS_SETTLE;
          tmr_load  = 1'b1;
          tmr_value = cds_len_q;
        end
      end
      ST_CDS_SETTLE: begin
        if (tmr_done) state_d = ST_DONE;
      end
      ST_PULSE_HIGH: begin
        if (tmr_done) begin
          state_d   = ST_PULSE_LOW;
          tmr_load  = 1'b1;
          tmr_value = gap_q;
        end
      end
      ST_PULSE_LOW: begin
        if (tmr_done) begin
          if (rem_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_PULSE_HIGH;
            tmr_load  = 1'b1;
            tmr_value = width_q;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Delayed trigger copies reset high so a trigger held through reset is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cds_trig_q    <= 1'b1;
      sample_trig_q <= 1'b1;
      dropped_q     <= 1'b0;
    end else begin
      cds_trig_q    <= cds_trigger;
      sample_trig_q <= sample_trigger;
      if ((state_q != ST_IDLE) && (cds_rise || sample_rise)) dropped_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cds_len_q     <= CNT_ONE;
      width_q       <= CNT_ONE;
      gap_q         <= CNT_ONE;
      rem_q         <= '0;
      pulse_count_q <= '0;
    end else begin
      if (state_q == ST_IDLE) begin
        if (cds_rise) begin
          cds_len_q <= eff(cds_cycles);
        end else if (sample_rise) begin
          width_q       <= eff(pulse_width);
          gap_q         <= eff(pulse_gap);
          rem_q         <= num_pulses;
          pulse_count_q <= '0;
        end
      end else if ((state_q == ST_PULSE_HIGH) && tmr_done) begin
        pulse_count_q <= pulse_count_q + CNT_ONE;
        rem_q         <= rem_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q   <= 1'b1;
      reset_q  <= 1'b0;
      cds_q    <= 1'b0;
      sample_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      idle_q   <= (state_d == ST_IDLE);
      reset_q  <= (state_d == ST_CDS_RESET);
      cds_q    <= (state_d == ST_CDS_SETTLE);
      sample_q <= (state_d == ST_PULSE_HIGH) || (state_d == ST_PULSE_LOW);
      pulse_q  <= (state_d == ST_PULSE_HIGH);
    end
  end

  assign idle          = idle_q;
  assign neuron_reset  = reset_q;
  assign neuron_cds    = cds_q;
  assign neuron_sample = sample_q;
  assign input_pulse   = pulse_q;
  assign pulse_count   = pulse_count_q;
  assign trig_dropped  = dropped_q;

endmodule

// File: tb/tb_neuron_pulse_sequencer.sv
// Bench for neuron_pulse_sequencer: per-cycle expected outputs computed from
// the sequence timing formulas (phase position within each pulse period).
module tb_neuron_pulse_sequencer;
  import neurram_ctrl_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             cds_trigger, sample_trigger;
  logic [CNT_W-1:0] num_pulses, pulse_width, pulse_gap, cds_cycles;
  logic             idle, neuron_reset, neuron_cds, neuron_sample, input_pulse;
  logic [CNT_W-1:0] pulse_count;
  logic             trig_dropped;

  int checks   = 0;
  int failures = 0;

  logic             dropped_exp;
  logic [CNT_W-1:0] count_exp;

  always #5 clk = ~clk;

  neuron_pulse_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .cds_trigger    (cds_trigger),
    .sample_trigger (sample_trigger),
    .num_pulses     (num_pulses),
    .pulse_width    (pulse_width),
    .pulse_gap      (pulse_gap),
    .cds_cycles     (cds_cycles),
    .idle           (idle),
    .neuron_reset   (neuron_reset),
    .neuron_cds     (neuron_cds),
    .neuron_sample  (neuron_sample),
    .input_pulse    (input_pulse),
    .pulse_count    (pulse_count),
    .trig_dropped   (trig_dropped)
  );

  // Field order: idle reset cds sample pulse dropped count
  function automatic logic [15:0] pack(input logic i, r, c, s, p, d,
                                       input logic [7:0] cnt);
    return {2'b00, i, r, c, s, p, d, cnt};
  endfunction

  function automatic logic [15:0] observed();
    return pack(idle, neuron_reset, neuron_cds, neuron_sample, input_pulse,
                trig_dropped, pulse_count);
  endfunction

  task automatic chk(input string tag, input int t, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    num_pulses  = 8'($urandom);
    pulse_width = 8'($urandom);
    pulse_gap   = 8'($urandom);
    cds_cycles  = 8'($urandom);
  endtask

  // Called just after a rising edge with triggers low.
  task automatic run_sample(input int n, input int w, input int g,
                            input int mid, input string tag);
    int we, ge, per, train, busy, ph, cnt;
    logic pend;
    logic [15:0] e;
    we    = (w == 0) ? 1 : w;
    ge    = (g == 0) ? 1 : g;
    per   = we + ge;
    train = n * per;
    busy  = train + 1;
    pend  = 1'b0;
    num_pulses     = 8'(n);
    pulse_width    = 8'(w);
    pulse_gap      = 8'(g);
    sample_trigger = 1'b1;
    next_cycle();
    for (int t = 0; t < busy + 3; t++) begin
      if (t < train) begin
        ph  = t % per;
        cnt = t / per + ((ph >= we) ? 1 : 0);
        e   = pack(1'b0, 1'b0, 1'b0, 1'b1, ph < we, dropped_exp, 8'(cnt));
      end else if (t == train) begin
        e = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, dropped_exp, 8'(n));
      end else begin
        e = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, dropped_exp, 8'(n));
      end
      @(negedge clk);
      chk(tag, t, observed(), e);
      next_cycle();
      if (pend) begin
        dropped_exp = 1'b1;
        pend        = 1'b0;
      end
      if (t + 1 == 1) scramble_inputs();
      if (t + 1 == 3) sample_trigger = 1'b0;
      if (mid > 0 && t + 1 == mid) begin
        sample_trigger = 1'b1;
        pend           = 1'b1;
      end
      if (mid > 0 && t + 1 == mid + 2) sample_trigger = 1'b0;
    end
    sample_trigger = 1'b0;
    count_exp      = 8'(n);
    next_cycle();
  endtask

  task automatic run_cds(input int c, input logic both, input string tag);
    int l, busy;
    logic [15:0] e;
    l = (c == 0) ? 1 : c;
    busy = 2 * l + 1;
    cds_cycles  = 8'(c);
    num_pulses  = 8'($urandom_range(1, 5));
    cds_trigger = 1'b1;
    if (both) sample_trigger = 1'b1;
    next_cycle();
    for (int t = 0; t < busy + 3; t++) begin
      if (t < l)          e = pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, dropped_exp, count_exp);
      else if (t < 2 * l) e = pack(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, dropped_exp, count_exp);
      else if (t == 2 * l) e = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, dropped_exp, count_exp);
      else                e = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, dropped_exp, count_exp);
      @(negedge clk);
      chk(tag, t, observed(), e);
      next_cycle();
      if (t + 1 == 1) scramble_inputs();
      if (t + 1 == 3) begin
        cds_trigger    = 1'b0;
        sample_trigger = 1'b0;
      end
    end
    cds_trigger    = 1'b0;
    sample_trigger = 1'b0;
    next_cycle();
  endtask

  initial begin
    rst            = 1'b1;
    cds_trigger    = 1'b0;
    sample_trigger = 1'b0;
    num_pulses     = '0;
    pulse_width    = '0;
    pulse_gap      = '0;
    cds_cycles     = '0;
    dropped_exp    = 1'b0;
    count_exp      = '0;
    #12;
    chk("reset_state", 0, observed(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    next_cycle();
    rst = 1'b0;
    next_cycle();

    run_cds(3, 1'b0, "cds3");
    run_sample(4, 2, 3, 0, "smp_4_2_3");
    run_sample(0, 2, 3, 0, "smp_n0");
    run_cds(2, 1'b1, "both_edges");
    run_cds(0, 1'b0, "cds0");
    run_sample(2, 0, 0, 0, "smp_w0g0");

    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 0)
        run_cds(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), "rnd_cds");
      else
        run_sample(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 0, "rnd_smp");
    end

    run_sample(4, 2, 3, 8, "smp_mid_edge");
    run_cds(1, 1'b0, "sticky_drop");

    // Reset during PULSE_HIGH with the sample trigger held high throughout.
    num_pulses     = 8'd3;
    pulse_width    = 8'd4;
    pulse_gap      = 8'd1;
    sample_trigger = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("pre_rst", 0, observed(), pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, dropped_exp, 8'd0));
    next_cycle();
    rst = 1'b1;
    #1;
    dropped_exp = 1'b0;
    count_exp   = '0;
    chk("rst_async", 0, observed(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    @(negedge clk);
    chk("rst_hold", 0, observed(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
    next_cycle();
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("post_rst_held_trig", t, observed(),
          pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0));
      next_cycle();
    end
    sample_trigger = 1'b0;
    next_cycle();
    run_sample(1, 1, 1, 0, "post_rst_smp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
